// File: rtl/seg7_byte_decoder.sv
// Seven-segment readback decoder: turns active-low digit patterns,
// low digit first, back into bytes on a valid/ready output.
module seg7_byte_decoder (
    input  logic       clock,
    input  logic       reset,
    input  logic [0:6] seg_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] byte_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        WAIT_LO,
        WAIT_HI,
        FULL
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] lo_q, lo_d;
    logic [7:0] byte_q, byte_d;
    logic       ov_q, ov_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] dig;
    logic       dig_ok;
    logic       accept;

    // Table is written with seg_in[0] (segment a) as the leftmost bit.
    always_comb begin
        dig    = 4'h0;
        dig_ok = 1'b1;
        case (seg_in)
            7'b0000001: dig = 4'h0;
            7'b1001111: dig = 4'h1;
            7'b0010010: dig = 4'h2;
            7'b0000110: dig = 4'h3;
            7'b1001100: dig = 4'h4;
            7'b0100100: dig = 4'h5;
            7'b0100000: dig = 4'h6;
            7'b0001111: dig = 4'h7;
            7'b0000000: dig = 4'h8;
            7'b0000100: dig = 4'h9;
            7'b0001000: dig = 4'hA;
            7'b1100000: dig = 4'hB;
            7'b0110001: dig = 4'hC;
            7'b1000010: dig = 4'hD;
            7'b0110000: dig = 4'hE;
            7'b0111000: dig = 4'hF;
            default:    dig_ok = 1'b0;
        endcase
    end

    assign in_ready = (state_q != FULL);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        byte_d  = byte_q;
        ov_d    = ov_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (accept && !dig_ok) begin
            err_d   = 1'b1;
            lo_d    = 4'h0;
            state_d = WAIT_LO;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                WAIT_LO: begin
                    if (accept) begin
                        lo_d    = dig;
                        state_d = WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (accept) begin
                        byte_d  = {dig, lo_q};
                        ov_d    = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        ov_d    = 1'b0;
                        state_d = WAIT_LO;
                    end
                end
                default: state_d = WAIT_LO;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= WAIT_LO;
            lo_q    <= 4'h0;
            byte_q  <= 8'h00;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            byte_q  <= byte_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_out  = byte_q;
    assign out_valid = ov_q;
    assign err       = err_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_seg7_byte_decoder.sv
// Directed bench for seg7_byte_decoder with an expected-byte queue.
module tb_seg7_byte_decoder;

    logic       clock;
    logic       reset;
    logic [0:6] seg_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] byte_out;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];
    logic [6:0] pat[16];
    logic [7:0] exp_b;
    logic [7:0] exp_cnt;

    seg7_byte_decoder dut (
        .clock     (clock),
        .reset     (reset),
        .seg_in    (seg_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .byte_out  (byte_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_count (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] p);
        @(negedge clock);
        seg_in   = p;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 4) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
        exp_b = sb.pop_front();
        chk({tag, "_byte"}, byte_out, exp_b);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({tag, "_ov_clr"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_hold"}, byte_out, exp_b);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"}, {7'd0, in_ready}, 8'd1);
        chk({tag, "_ov"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_byte"}, byte_out, 8'h00);
        chk({tag, "_err"}, {7'd0, err}, 8'd0);
        chk({tag, "_cnt"}, err_count, 8'h00);
    endtask

    initial begin
        pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        reset     = 1'b0;
        seg_in    = 7'h7F;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk_reset("rst0");
        reset = 1'b1;

        send(pat[1]);
        send(pat[3]);
        sb.push_back(8'h31);
        chk("lat_ov", {7'd0, out_valid}, 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_byte", byte_out, 8'h31);
            chk("stall_ov", {7'd0, out_valid}, 8'd1);
            chk("stall_rdy", {7'd0, in_ready}, 8'd0);
        end
        pop_check("p31");

        for (int i = 0; i < 16; i++) begin
            send(pat[i]);
            send(pat[14]);
            sb.push_back({4'hE, 4'(i)});
            pop_check("sweep");
        end

        send(pat[10]);
        send(7'h7F);
        chk("inv_err", {7'd0, err}, 8'd1);
        chk("inv_cnt", err_count, 8'd1);
        chk("inv_ov", {7'd0, out_valid}, 8'd0);
        @(negedge clock);
        chk("inv_err_clr", {7'd0, err}, 8'd0);
        send(pat[12]);
        send(pat[13]);
        sb.push_back(8'hDC);
        pop_check("pDC");

        send(pat[2]);
        send(pat[7]);
        sb.push_back(8'h72);
        seg_in   = pat[8];
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("full_rdy", {7'd0, in_ready}, 8'd0);
        end
        in_valid = 1'b0;
        pop_check("p72");
        send(pat[0]);
        send(pat[0]);
        sb.push_back(8'h00);
        pop_check("p00");

        @(negedge clock);
        seg_in   = 7'h7F;
        in_valid = 1'b1;
        exp_cnt  = 8'd1;
        for (int k = 0; k < 260; k++) begin
            @(negedge clock);
            seg_in  = (k % 2 == 0) ? 7'b1111110 : 7'h7F;
            exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
            chk("burst_err", {7'd0, err}, 8'd1);
            chk("burst_cnt", err_count, exp_cnt);
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("sat_err", {7'd0, err}, 8'd0);
        chk("sat_cnt", err_count, 8'hFF);

        send(pat[9]);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk_reset("rst_hi");
        send(pat[9]);
        send(pat[5]);
        chk("pre_rst_full", byte_out, 8'h59);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk_reset("rst_full");
        send(pat[9]);
        send(pat[5]);
        sb.push_back(8'h59);
        pop_check("p59");

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
